// File: rtl/clint_timer_if.sv
// Data-bus slave port of the CLINT: single-beat requests, one-cycle-latency responses.
interface clint_timer_if;
  logic        bus_req_in;
  logic        bus_we_in;
  logic [4:0]  bus_addr_in;
  logic [31:0] bus_wdata_in;
  logic [31:0] bus_rdata_out;
  logic        bus_ack_out;
  logic        bus_err_out;

  modport master (
    output bus_req_in, bus_we_in, bus_addr_in, bus_wdata_in,
    input  bus_rdata_out, bus_ack_out, bus_err_out
  );

  modport slave (
    input  bus_req_in, bus_we_in, bus_addr_in, bus_wdata_in,
    output bus_rdata_out, bus_ack_out, bus_err_out
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: prescaled 64-bit mtime, mtimecmp compare and msip,
// exposed as a memory-mapped slave producing the machine timer/software irq levels.
module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic         clk_in,
  input  logic         reset_in,
  clint_timer_if.slave bus,
  output logic         timer_irq_out,
  output logic         soft_irq_out
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [4:0] ADDR_MSIP    = 5'h00;
  localparam logic [4:0] ADDR_CMP_LO  = 5'h04;
  localparam logic [4:0] ADDR_CMP_HI  = 5'h08;
  localparam logic [4:0] ADDR_TIME_LO = 5'h0C;
  localparam logic [4:0] ADDR_TIME_HI = 5'h10;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          msip_q, msip_d;
  logic          ack_q, err_q, err_d;
  logic          tirq_q;
  logic [4:0]    addr;
  logic          mapped, wr, rd, tick;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    addr    = bus.bus_addr_in;
    mapped  = (addr[1:0] == 2'b00) && (addr <= ADDR_TIME_HI);
    wr      = bus.bus_req_in &&  bus.bus_we_in && mapped;
    rd      = bus.bus_req_in && !bus.bus_we_in && mapped;
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    shadow_d   = shadow_q;
    rdata_d    = '0;
    err_d      = bus.bus_req_in && !mapped;

    // Reads see the pre-edge state; a LO read also captures HI for an atomic pair.
    if (rd) begin
      case (addr)
        ADDR_MSIP:    rdata_d = {31'b0, msip_q};
        ADDR_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        ADDR_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        ADDR_TIME_LO: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        ADDR_TIME_HI: rdata_d = shadow_q;
        default:      rdata_d = '0;
      endcase
    end

    // An mtime write replaces the increment outright: no tick, no carry this cycle.
    if (wr) begin
      case (addr)
        ADDR_MSIP:    msip_d     = bus.bus_wdata_in[0];
        ADDR_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata_in};
        ADDR_CMP_HI:  mtimecmp_d = {bus.bus_wdata_in, mtimecmp_q[31:0]};
        ADDR_TIME_LO: mtime_d    = {mtime_q[63:32], bus.bus_wdata_in};
        ADDR_TIME_HI: mtime_d    = {bus.bus_wdata_in, mtime_q[31:0]};
        default:      ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      shadow_q   <= '0;
      rdata_q    <= '0;
      msip_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      tirq_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      ack_q      <= bus.bus_req_in;
      err_q      <= err_d;
      tirq_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  assign bus.bus_ack_out   = ack_q;
  assign bus.bus_err_out   = err_q;
  assign bus.bus_rdata_out = rdata_q;
  assign timer_irq_out     = tirq_q;
  assign soft_irq_out      = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 1 and 4) share one random/directed
// bus stream and are compared every cycle against an arithmetic model of the register file.
module tb_clint_timer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req, we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        chk_en = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk_in = ~clk_in;

  clint_timer_if bus_a ();
  clint_timer_if bus_b ();

  assign bus_a.bus_req_in   = req;
  assign bus_a.bus_we_in    = we;
  assign bus_a.bus_addr_in  = addr;
  assign bus_a.bus_wdata_in = wdata;
  assign bus_b.bus_req_in   = req;
  assign bus_b.bus_we_in    = we;
  assign bus_b.bus_addr_in  = addr;
  assign bus_b.bus_wdata_in = wdata;

  logic [1:0] timer_irq, soft_irq, ack_w, err_w;
  logic [31:0] rdata_w [2];

  assign ack_w[0]   = bus_a.bus_ack_out;
  assign ack_w[1]   = bus_b.bus_ack_out;
  assign err_w[0]   = bus_a.bus_err_out;
  assign err_w[1]   = bus_b.bus_err_out;
  assign rdata_w[0] = bus_a.bus_rdata_out;
  assign rdata_w[1] = bus_b.bus_rdata_out;

  clint_timer #(.TICK_DIV(1)) dut_a (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus_a),
    .timer_irq_out(timer_irq[0]), .soft_irq_out(soft_irq[0])
  );

  clint_timer #(.TICK_DIV(4)) dut_b (
    .clk_in(clk_in), .reset_in(reset_in), .bus(bus_b),
    .timer_irq_out(timer_irq[1]), .soft_irq_out(soft_irq[1])
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] shadow;
    logic [31:0] rdata;
    logic        msip;
    logic        ack;
    logic        err;
    logic        chk_rd;
    logic        tirq;
    int unsigned cyc;
  } model_t;

  model_t      m [2];
  int unsigned div_of [2] = '{1, 4};

  function automatic void model_step(input int i);
    logic ok;
    logic wrote_time;
    ok            = (addr % 4 == 0) && (addr <= 16);
    m[i].ack      = req;
    m[i].err      = req && !ok;
    m[i].chk_rd   = req && (!we || !ok);
    m[i].rdata    = 0;
    m[i].tirq     = (m[i].mtime >= m[i].cmp);
    if (req && !we && ok) begin
      case (addr)
        0:  m[i].rdata = {31'b0, m[i].msip};
        4:  m[i].rdata = m[i].cmp[31:0];
        8:  m[i].rdata = m[i].cmp[63:32];
        12: begin m[i].rdata = m[i].mtime[31:0]; m[i].shadow = m[i].mtime[63:32]; end
        default: m[i].rdata = m[i].shadow;
      endcase
    end
    wrote_time = 1'b0;
    if (req && we && ok) begin
      case (addr)
        0:  m[i].msip = wdata[0];
        4:  m[i].cmp[31:0]  = wdata;
        8:  m[i].cmp[63:32] = wdata;
        12: begin m[i].mtime[31:0]  = wdata; wrote_time = 1'b1; end
        default: begin m[i].mtime[63:32] = wdata; wrote_time = 1'b1; end
      endcase
    end
    if (!wrote_time && (m[i].cyc % div_of[i] == div_of[i] - 1))
      m[i].mtime = m[i].mtime + 64'd1;
    m[i].cyc++;
  endfunction

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < 2; i++) begin
        m[i].mtime  = '0;
        m[i].cmp    = '1;
        m[i].shadow = '0;
        m[i].rdata  = '0;
        m[i].msip   = 1'b0;
        m[i].ack    = 1'b0;
        m[i].err    = 1'b0;
        m[i].chk_rd = 1'b0;
        m[i].tirq   = 1'b0;
        m[i].cyc    = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ack[%0d]", i), ack_w[i], m[i].ack);
        if (m[i].ack) check($sformatf("err[%0d]", i), err_w[i], m[i].err);
        if (m[i].ack && m[i].chk_rd) check($sformatf("rdata[%0d]", i), rdata_w[i], m[i].rdata);
        check($sformatf("timer_irq[%0d]", i), timer_irq[i], m[i].tirq);
        check($sformatf("soft_irq[%0d]", i), soft_irq[i], m[i].msip);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_op(input logic w, input logic [4:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk_in); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wait_irq(input int idx, input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (timer_irq[idx] !== level && n < budget) begin
      @(posedge clk_in); #1;
      n++;
    end
    check(name, timer_irq[idx], level);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    reset_in = 1'b0;
    #1 reset_in = 1'b1;
    #1 chk_en = 1'b1;
    #10 reset_in = 1'b0;

    // 1: ten idle ticks, then read MTIME_LO
    idle(10);
    check("t1_timer_idle", timer_irq[0], 1'b0);
    bus_op(1'b0, 5'h0C, '0);
    total++;
    if (!(rdata_w[0] >= 9 && rdata_w[0] <= 11)) begin
      bad++;
      $display("FAIL t1_mtime_lo: got %0d, expected 9..11", rdata_w[0]);
    end

    // 2: compare at 0x40, then raise compare above mtime
    bus_op(1'b1, 5'h08, 32'h0);
    bus_op(1'b1, 5'h04, 32'h40);
    wait_irq(0, 1'b1, 200, "t2_irq_rise_a");
    wait_irq(1, 1'b1, 400, "t2_irq_rise_b");
    bus_op(1'b1, 5'h04, 32'hFFFF_FFFF);
    idle(1);
    check("t2_irq_fall_a", timer_irq[0], 1'b0);
    check("t2_irq_fall_b", timer_irq[1], 1'b0);

    // 3: software interrupt
    bus_op(1'b1, 5'h00, 32'hFFFF_FFFF);
    check("t3_soft_set", soft_irq[0], 1'b1);
    bus_op(1'b0, 5'h00, '0);
    check("t3_msip_read", rdata_w[0], 32'h1);
    bus_op(1'b1, 5'h00, 32'h0);
    check("t3_soft_clr", soft_irq[0], 1'b0);

    // 4: run mtime into the 64-bit wrap with compare at all-ones
    bus_op(1'b1, 5'h08, 32'hFFFF_FFFF);
    bus_op(1'b1, 5'h10, 32'hFFFF_FFFF);
    bus_op(1'b1, 5'h0C, 32'hFFFF_FFFE);
    idle(2);
    check("t4_irq_at_max", timer_irq[0], 1'b1);
    idle(1);
    check("t4_irq_after_wrap", timer_irq[0], 1'b0);
    bus_op(1'b0, 5'h0C, '0);
    bus_op(1'b0, 5'h10, '0);
    check("t4_hi_after_wrap", rdata_w[0], 32'h0);

    // 5: write MTIME_LO on the divide-by-4 increment cycle
    while (m[1].cyc % 4 != 3) idle(1);
    bus_op(1'b1, 5'h0C, 32'h1234_5678);
    bus_op(1'b0, 5'h0C, '0);
    check("t5_write_wins_b", rdata_w[1], 32'h1234_5678);
    check("t5_write_wins_a", rdata_w[0], 32'h1234_5678);

    // 6a: unaligned and out-of-range offsets
    bus_op(1'b0, 5'h02, '0);
    check("t6_err_02", {ack_w[0], err_w[0], rdata_w[0]}, {1'b1, 1'b1, 32'h0});
    bus_op(1'b0, 5'h14, '0);
    check("t6_err_14", {ack_w[0], err_w[0], rdata_w[0]}, {1'b1, 1'b1, 32'h0});

    // random traffic, mostly mapped offsets, with compare values biased low
    for (int k = 0; k < 400; k++) begin
      int r;
      r     = $urandom_range(0, 9);
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1);
      addr  = (r < 8) ? 5'($urandom_range(0, 4) * 4) : 5'($urandom_range(0, 31));
      wdata = $urandom;
      if (addr == 5'h08 && $urandom_range(0, 1) == 1) wdata = 32'h0;
      if (addr == 5'h04 && $urandom_range(0, 1) == 1) wdata = $urandom_range(0, 64);
      @(posedge clk_in); #1;
    end
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // 6b: reset during a pending ack with both irqs raised
    bus_op(1'b1, 5'h00, 32'h1);
    bus_op(1'b1, 5'h08, 32'h0);
    bus_op(1'b1, 5'h04, 32'h0);
    idle(2);
    check("t6_irq_before_rst", timer_irq[0], 1'b1);
    bus_op(1'b0, 5'h0C, '0);
    #2 reset_in = 1'b1;
    #1;
    check("t6_rst_outputs_a", {ack_w[0], timer_irq[0], soft_irq[0]}, 3'b000);
    check("t6_rst_outputs_b", {ack_w[1], timer_irq[1], soft_irq[1]}, 3'b000);
    @(posedge clk_in); #1 reset_in = 1'b0;
    bus_op(1'b0, 5'h04, '0);
    check("t6_cmp_lo_reset", rdata_w[0], 32'hFFFF_FFFF);
    bus_op(1'b0, 5'h08, '0);
    check("t6_cmp_hi_reset", rdata_w[1], 32'hFFFF_FFFF);
    idle(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
